irq_arbiter: RTL
================

// Module: irq_arbiter
// PURPOSE
//   Collects interrupt requests from N_SRC external sources, latches them on rising edges,
//   and picks one by fixed priority (index 0 = highest). Drives the single ExtIRQ line into
//   the processor controller and reports the granted source ID for the exception syndrome.
//   Sequences the handshake as request -> ExtIAck -> in service -> ERet, so only one external
//   interrupt is in service at a time (no nesting).
// PARAMETERS
//   N_SRC  4                 number of interrupt sources (legal range: 2..16)
//   ID_W   $clog2(N_SRC)     width of irq_id
// PORTS
//   clk         in   1      system clock, rising edge
//   reset       in   1      asynchronous, active-high
//   irq_req     in   N_SRC  raw request lines, synchronous to clk, edge-sensitive
//   irq_mask    in   N_SRC  1 = source masked (pending is kept, never selected)
//   ExtIAck     in   1      controller acknowledge (ExcAck && ExtIRQ), 1-cycle pulse
//   ERet        in   1      controller decoded ERET; return from exception, 1-cycle pulse
//   ExtIRQ      out  1      external interrupt request to the controller
//   irq_id      out  ID_W   ID of the selected/in-service source
//   irq_ack     out  N_SRC  one-hot 1-cycle grant pulse back to the source
//   in_service  out  1      an external interrupt is being serviced
//   pending     out  N_SRC  latched, not-yet-granted requests
//   overrun     out  N_SRC  sticky: an edge arrived while pending[i] was already 1
// BEHAVIOUR
//   Reset: state=IDLE; ExtIRQ=0, irq_id=0, irq_ack=0, in_service=0, pending=0, overrun=0,
//     irq_req_q=0. All outputs are registered. Reset mid-handshake aborts it with no ack pulse.
//   Edge detect: rise[i] = irq_req[i] & ~irq_req_q[i]. irq_req_q is registered every cycle.
//   pending[i] is set on rise[i]. It clears only on the grant of i.
//   A rise and a grant of the same i in the same cycle leaves pending[i]=1 (set wins).
//   rise[i] while pending[i]=1 and not being granted sets overrun[i]. overrun clears only on reset.
//   eligible = pending & ~irq_mask; sel = lowest set index of eligible.
//   FSM:
//     IDLE:    if eligible != 0 -> REQ; irq_id <= sel; ExtIRQ <= 1.
//     REQ:     ExtIRQ holds at 1 and irq_id is frozen, even if irq_mask changes (committed).
//              on ExtIAck -> SERVICE; ExtIRQ <= 0; in_service <= 1;
//              irq_ack[irq_id] <= 1 for exactly one cycle; pending[irq_id] <= 0.
//     SERVICE: new edges are still latched, nothing is selected.
//              on ERet -> IDLE; in_service <= 0.
//   ERet in IDLE or REQ is ignored. ExtIAck in IDLE or SERVICE is ignored.
//   Latency: rise sampled at edge t -> pending at t -> ExtIRQ=1 after edge t+1
//     (assuming IDLE and unmasked).
//   Back-to-back: after ERet, IDLE reselects at the next edge, so ExtIRQ can rise 1 cycle
//     after in_service falls.
//   A masked pending source becomes eligible the cycle its mask bit clears.
//   A level held high produces one request only. It must drop and rise again to re-request.
// TESTING
//   1. Edge on irq_req[2] at t, no mask -> ExtIRQ=1, irq_id=2 at t+2. Hold ExtIAck low
//      10 cycles -> ExtIRQ stays 1.
//   2. ExtIAck pulse in REQ -> next cycle irq_ack=4'b0100 for one cycle, pending[2]=0,
//      in_service=1, ExtIRQ=0. ERet -> in_service=0.
//   3. Same-cycle edges on sources 1 and 3 -> irq_id=1 served first. After ERet,
//      irq_id=3 is requested, ExtIRQ rises 1 cycle after in_service falls.
//   4. irq_mask=4'b0001 with edge on source 0 -> no ExtIRQ, pending[0]=1.
//      Clear the mask -> ExtIRQ=1, irq_id=0.
//   5. Two edges on source 1 before its grant -> overrun[1]=1 and it stays set after service.
//      ERet/ExtIAck pulses while IDLE -> no state change.
//   6. Assert reset while in REQ with pending=4'b1010 -> all outputs 0, no irq_ack pulse,
//      FSM back in IDLE.

Source files
------------

// File: rtl/irq_arbiter_if.sv
// Signal bundle between the interrupt arbiter, its sources and the processor controller.
// Handshake: ExtIRQ is held with irq_id frozen until ExtIAck; ERet ends service.
interface irq_arbiter_if #(
  parameter int N_SRC = 4,
  parameter int ID_W  = $clog2(N_SRC)
);
  logic [N_SRC-1:0] irq_req;
  logic [N_SRC-1:0] irq_mask;
  logic             ExtIAck;
  logic             ERet;
  logic             ExtIRQ;
  logic [ID_W-1:0]  irq_id;
  logic [N_SRC-1:0] irq_ack;
  logic             in_service;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] overrun;
  logic [1:0]       fsm_state;

  modport master (
    input  irq_req, irq_mask, ExtIAck, ERet,
    output ExtIRQ, irq_id, irq_ack, in_service, pending, overrun, fsm_state
  );

  modport slave (
    output irq_req, irq_mask, ExtIAck, ERet,
    input  ExtIRQ, irq_id, irq_ack, in_service, pending, overrun, fsm_state
  );
endinterface

// File: rtl/irq_arbiter.sv
// Edge-latching fixed-priority interrupt arbiter; one non-nested external interrupt
// is sequenced through request, acknowledge and return-from-exception.
module irq_arbiter #(
  parameter int N_SRC = 4,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input logic            clk,
  input logic            reset,
  irq_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [N_SRC-1:0] req_q;
  logic [N_SRC-1:0] pending_q, pending_n;
  logic [N_SRC-1:0] overrun_q, overrun_n;
  logic [N_SRC-1:0] irq_ack_q, irq_ack_n;
  logic             ext_irq_q, ext_irq_n;
  logic             in_service_q, in_service_n;
  logic [ID_W-1:0]  irq_id_q, irq_id_n;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] grant_vec;
  logic [ID_W-1:0]  sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      req_q        <= '0;
      pending_q    <= '0;
      overrun_q    <= '0;
      irq_ack_q    <= '0;
      ext_irq_q    <= 1'b0;
      in_service_q <= 1'b0;
      irq_id_q     <= '0;
    end else begin
      state_q      <= state_n;
      req_q        <= bus.irq_req;
      pending_q    <= pending_n;
      overrun_q    <= overrun_n;
      irq_ack_q    <= irq_ack_n;
      ext_irq_q    <= ext_irq_n;
      in_service_q <= in_service_n;
      irq_id_q     <= irq_id_n;
    end
  end

  always_comb begin
    rise      = bus.irq_req & ~req_q;
    eligible  = pending_q & ~bus.irq_mask;
    grant_vec = '0;
    sel       = '0;
    // Descending scan so the lowest eligible index is the one left in sel.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel = i[ID_W-1:0];
    end

    state_n      = state_q;
    ext_irq_n    = ext_irq_q;
    in_service_n = in_service_q;
    irq_id_n     = irq_id_q;
    irq_ack_n    = '0;

    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_n   = REQ;
          irq_id_n  = sel;
          ext_irq_n = 1'b1;
        end
      end
      REQ: begin
        if (bus.ExtIAck) begin
          grant_vec    = {{(N_SRC-1){1'b0}}, 1'b1} << irq_id_q;
          state_n      = SERVICE;
          ext_irq_n    = 1'b0;
          in_service_n = 1'b1;
          irq_ack_n    = grant_vec;
        end
      end
      SERVICE: begin
        if (bus.ERet) begin
          state_n      = IDLE;
          in_service_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    // A fresh edge in the grant cycle keeps the bit pending.
    pending_n = (pending_q & ~grant_vec) | rise;
    overrun_n = overrun_q | (rise & pending_q & ~grant_vec);
  end

  assign bus.ExtIRQ     = ext_irq_q;
  assign bus.irq_id     = irq_id_q;
  assign bus.irq_ack    = irq_ack_q;
  assign bus.in_service = in_service_q;
  assign bus.pending    = pending_q;
  assign bus.overrun    = overrun_q;
  assign bus.fsm_state  = state_q;

endmodule
